prio_encode8to3: RTL and testbench

PRIO_ENCODE8TO3 -- requirements
Module: prio_encode8to3

---
 rtl/prio_encode8to3.sv | 62 ++++++
 tb/tb_prio_encode8to3.sv | 138 +++++++++++++
 2 files changed

// File: rtl/prio_encode8to3.sv
// prio_encode8to3: captures request edges/levels into a pending register and issues
// the highest-priority pending index through a valid/ready handshake.
module prio_encode8to3 #(
  parameter int EDGE = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req,
  input  logic       en,
  output logic [2:0] code,
  output logic       valid,
  input  logic       ready,
  output logic [7:0] pend,
  output logic [3:0] count,
  output logic       drop
);
  typedef enum logic {IDLE, HOLD} state_t;
  state_t     r_state, w_state_nxt;
  logic [7:0] r_req_q, r_pend, w_hit, w_cap, w_clr, w_pend_nxt;
  logic [2:0] r_code, w_top;
  logic [3:0] r_count, w_cnt;
  logic       r_drop, r_arm, w_load;
  // r_arm masks the first edge after reset so a line already high is not seen as a rise
  always_comb begin
    w_hit = (EDGE != 0) ? (r_arm ? 8'h00 : req & ~r_req_q) : req;
    w_cap = en ? w_hit : 8'h00;
    w_clr = (r_state == HOLD && ready) ? 8'd1 << r_code : 8'h00;
    w_pend_nxt = (r_pend & ~w_clr) | w_cap;
    w_top = 3'd0;
    w_cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pend[i]) w_top = 3'(i);
      w_cnt = w_cnt + 4'(w_pend_nxt[i]);
    end
    w_load = (r_state == IDLE) && en && (r_pend != 8'h00);
    w_state_nxt = w_load ? HOLD : (r_state == HOLD && ready) ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_code  <= 3'd0;
      r_pend  <= 8'h00;
      r_count <= 4'd0;
      r_drop  <= 1'b0;
      r_req_q <= 8'h00;
      r_arm   <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_code  <= w_load ? w_top : r_code;
      r_pend  <= w_pend_nxt;
      r_count <= w_cnt;
      r_drop  <= r_drop | (|(w_cap & r_pend & ~w_clr));
      r_req_q <= req;
      r_arm   <= 1'b0;
    end
  end
  assign code  = r_code;
  assign valid = (r_state == HOLD);
  assign pend  = r_pend;
  assign count = r_count;
  assign drop  = r_drop;
endmodule

// File: tb/tb_prio_encode8to3.sv
// tb_prio_encode8to3: table-driven directed vectors plus a reset-in-HOLD sequence.
module tb_prio_encode8to3;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req;
  logic       en, ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pend;
  logic [3:0] count;
  logic       drop;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] req;
    logic       en, rdy;
    logic [7:0] p;
    logic       v;
    logic [2:0] c;
    logic [3:0] n;
    logic       d;
  } vec_t;
  vec_t vq[$];

  prio_encode8to3 #(.EDGE(1)) dut (
    .clk(clk), .reset(reset), .req(req), .en(en), .code(code), .valid(valid),
    .ready(ready), .pend(pend), .count(count), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input logic v,
                         input logic [2:0] c, input logic [3:0] n, input logic d);
    chk({tag, ".pend"}, int'(pend), int'(p));
    chk({tag, ".valid"}, int'(valid), int'(v));
    chk({tag, ".code"}, int'(code), int'(c));
    chk({tag, ".count"}, int'(count), int'(n));
    chk({tag, ".drop"}, int'(drop), int'(d));
  endtask

  task automatic add(input logic [7:0] r, input logic e, input logic rd, input logic [7:0] p,
                     input logic v, input logic [2:0] c, input logic [3:0] n, input logic d);
    vq.push_back('{r, e, rd, p, v, c, n, d});
  endtask

  initial begin
    add(8'h00,1,1,8'h00,0,0,0,0);
    add(8'h04,1,1,8'h04,0,0,1,0);
    add(8'h04,1,1,8'h04,1,2,1,0);
    add(8'h04,1,1,8'h00,0,2,0,0);
    add(8'h00,1,1,8'h00,0,2,0,0);
    add(8'h81,1,1,8'h81,0,2,2,0);
    add(8'h81,1,1,8'h81,1,7,2,0);
    add(8'h81,1,1,8'h01,0,7,1,0);
    add(8'h81,1,1,8'h01,1,0,1,0);
    add(8'h81,1,1,8'h00,0,0,0,0);
    add(8'h00,1,1,8'h00,0,0,0,0);
    add(8'h08,1,0,8'h08,0,0,1,0);
    add(8'h08,1,0,8'h08,1,3,1,0);
    for (int k = 0; k < 5; k++) add(8'h88,1,0,8'h88,1,3,2,0);
    add(8'h88,1,1,8'h80,0,3,1,0);
    add(8'h88,1,1,8'h80,1,7,1,0);
    add(8'h88,1,1,8'h00,0,7,0,0);
    add(8'h00,1,1,8'h00,0,7,0,0);
    add(8'h20,0,1,8'h00,0,7,0,0);
    add(8'h00,0,1,8'h00,0,7,0,0);
    add(8'h20,1,1,8'h20,0,7,1,0);
    add(8'h20,1,1,8'h20,1,5,1,0);
    add(8'h20,1,1,8'h00,0,5,0,0);
    add(8'h00,1,1,8'h00,0,5,0,0);
    add(8'h04,1,0,8'h04,0,5,1,0);
    add(8'h00,1,0,8'h04,1,2,1,0);
    add(8'h04,1,0,8'h04,1,2,1,1);
    add(8'h04,1,1,8'h00,0,2,0,1);
    add(8'h00,1,1,8'h00,0,2,0,1);
    add(8'h08,1,0,8'h08,0,2,1,1);
    add(8'h00,1,0,8'h08,1,3,1,1);
    add(8'h08,1,1,8'h08,0,3,1,1);
    add(8'h08,1,1,8'h08,1,3,1,1);
    add(8'h00,1,1,8'h00,0,3,0,1);
    add(8'h10,1,0,8'h10,0,3,1,1);
    add(8'h00,1,0,8'h10,1,4,1,1);
    add(8'h00,0,1,8'h00,0,4,0,1);

    reset = 1'b1; req = 8'h00; en = 1'b0; ready = 1'b0;
    #3;
    chk_all("por", 8'h00, 0, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    foreach (vq[k]) begin
      req = vq[k].req; en = vq[k].en; ready = vq[k].rdy;
      tick();
      chk_all($sformatf("row%0d", k), vq[k].p, vq[k].v, vq[k].c, vq[k].n, vq[k].d);
    end

    req = 8'hC0; en = 1'b1; ready = 1'b0;
    tick();
    chk_all("rst_a", 8'hC0, 0, 4, 2, 1);
    tick();
    chk_all("rst_b", 8'hC0, 1, 7, 2, 1);
    #2 reset = 1'b1;
    #1 chk_all("rst_async", 8'h00, 0, 0, 0, 0);
    tick();
    reset = 1'b0;
    ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all($sformatf("post%0d", k), 8'h00, 0, 0, 0, 0);
    end
    req = 8'h00;
    tick();
    req = 8'h40;
    tick();
    chk_all("new_a", 8'h40, 0, 0, 1, 0);
    tick();
    chk_all("new_b", 8'h40, 1, 6, 1, 0);
    tick();
    chk_all("new_c", 8'h00, 0, 6, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
